mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree. It generalises the fixed 8:1 binary tree of 2:1 stages to any power-of-two input count and any data width. Each tree level is registered, and the block carries a valid/ready handshake with backpressure. It sits between a bank of N parallel data sources and a single downstream consumer, e.g. a channel-select datapath ahead of a serialiser. An optional auto-scan mode steps the select round-robin by itself.

## Interface
- N, 8: input count; power of two, >= 2.
- W, 1: data width per input, >= 1.
- LOG2N (localparam), $clog2(N): tree depth, select width and latency.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*W  input i is in_data[i*W +: W].
- in_sel  in  LOG2N  input index to forward.
- in_valid  in  1  in_data/in_sel are valid this cycle.
- in_ready  out  1  block accepts a beat this cycle.
- out_data  out  W  selected data.
- out_sel  out  LOG2N  index that produced out_data.
- out_valid  out  1  out_data/out_sel are valid.
- out_ready  in  1  consumer accepts the output beat.
- scan_mode  in  1  only with MUX_TREE_SCAN_EN; 1 = use the internal scan counter instead of in_sel.

## Operation
- Tree: level k (k = 0..LOG2N-1) has N/2^(k+1) 2:1 cells. Each cell picks the upper element of its pair when effective select bit k = 1. Level 0 pairs inputs (2j+1, 2j). Result: out_data = input[sel], with LSB-first decoding exactly like the 8:1 tree.
- Pipeline: each level ends in a register stage (LOG2N stages). Each stage holds its partial results, the full select and a valid bit. Data, select and valid move together.
- Advance rule: advance = out_ready | ~out_valid. When advance = 1, all stages shift one place. When advance = 0, all stages hold.
- in_ready = advance (combinational, no dependence on in_valid).
- A beat is accepted when in_valid & in_ready. If in_valid = 0 while advancing, a bubble (valid = 0) enters stage 0.
- Bubbles are not compressed. A stalled pipeline stalls as a whole.
- out_data, out_sel and out_valid come straight from the last stage registers; there is no combinational input-to-output path.
- Out-of-range select cannot occur because the select width is exactly LOG2N.

## Timing
- Reset (rst_n low, asynchronous): every stage valid = 0, data = 0, select = 0. So out_valid = 0, out_data = 0, out_sel = 0.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- First edge after rst_n rises: the block accepts a beat if in_valid = 1 (in_ready = 1 because out_valid = 0).
- Latency: a beat accepted at edge t appears on out_valid after edge t+LOG2N-1, assuming no stalls; LOG2N cycles of latency in total. For N = 8: 3 cycles.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: with out_valid = 1 and out_ready = 0, the output is held stable and in_ready = 0. Input is not sampled.
- out_ready may toggle while out_valid = 0 without effect.

## Configuration
- MUX_TREE_SCAN_EN defined:
  - Adds the scan_mode port and a LOG2N-bit scan counter, reset to 0.
  - While scan_mode = 1, the effective select is the counter and in_sel is ignored.
  - The counter increments on every accepted beat with scan_mode = 1 and wraps from N-1 to 0.
  - The counter holds on stalls, on bubbles and while scan_mode = 0. It is not cleared when scan_mode toggles.
  - out_sel reports the counter value used.
- MUX_TREE_SCAN_EN undefined: no scan_mode port, no counter; the effective select is always in_sel.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 2 beats in flight -> out_valid = 0, out_data = 0, out_sel = 0 immediately. No stale beat appears after release.
- Select sweep: N = 8, W = 8, input i = 8'hA0+i, in_sel = 0..7 on consecutive cycles, out_ready = 1 -> out_data = A0..A7 and out_sel = 0..7, the first appearing 3 cycles after the first accept.
- Backpressure: stream 5 beats and drop out_ready for 4 cycles while out_valid = 1 -> output held, in_ready = 0. All 5 beats delivered in order with none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid pattern 1,0,1,1,0, delayed by LOG2N cycles.
- Parametrisation: N = 2, W = 1 (latency 1) and N = 16, W = 32 (latency 4). Random selects checked against a reference model.
- Scan (MUX_TREE_SCAN_EN): scan_mode = 1, 10 accepted beats with in_sel = 5 held -> out_sel = 0..7,0,1. A stall in between does not advance the counter.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree with one register stage per tree level and valid/ready flow.
// Optional round-robin auto-scan of the select is enabled with `define MUX_TREE_SCAN_EN.
module mux_tree_pipe #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1,
  localparam int unsigned LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [LOG2N-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic [LOG2N-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_TREE_SCAN_EN
  ,
  input  logic             scan_mode
`endif
);

  logic             w_advance;
  logic [LOG2N-1:0] w_eff_sel;

  // The whole pipeline moves or holds as one; bubbles are never squeezed out.
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance;

`ifdef MUX_TREE_SCAN_EN
  logic [LOG2N-1:0] r_scan_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
    end else if (scan_mode && in_valid && w_advance) begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_eff_sel = scan_mode ? r_scan_cnt : in_sel;
`else
  assign w_eff_sel = in_sel;
`endif

  for (genvar k = 0; k < LOG2N; k++) begin : g_lvl
    localparam int unsigned M = N >> (k + 1);

    logic [2*M*W-1:0] w_src_data;
    logic [LOG2N-1:0] w_src_sel;
    logic             w_src_valid;
    logic [M*W-1:0]   w_mux;
    logic [M*W-1:0]   r_data;
    logic [LOG2N-1:0] r_sel;
    logic             r_valid;

    if (k == 0) begin : g_head
      assign w_src_data  = in_data;
      assign w_src_sel   = w_eff_sel;
      assign w_src_valid = in_valid;
    end else begin : g_body
      assign w_src_data  = g_lvl[k-1].r_data;
      assign w_src_sel   = g_lvl[k-1].r_sel;
      assign w_src_valid = g_lvl[k-1].r_valid;
    end

    // Level k decodes select bit k: LSB-first, upper element of each pair on 1.
    always_comb begin
      w_mux = '0;
      for (int unsigned j = 0; j < M; j++) begin
        w_mux[j*W +: W] = w_src_sel[k] ? w_src_data[(2*j+1)*W +: W] : w_src_data[2*j*W +: W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data  <= '0;
        r_sel   <= '0;
        r_valid <= 1'b0;
      end else if (w_advance) begin
        r_data  <= w_mux;
        r_sel   <= w_src_sel;
        r_valid <= w_src_valid;
      end
    end
  end

  assign out_data  = g_lvl[LOG2N-1].r_data;
  assign out_sel   = g_lvl[LOG2N-1].r_sel;
  assign out_valid = g_lvl[LOG2N-1].r_valid;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: three sizes run side by side against a queue model
// of a LOG2N-deep lockstep pipeline.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A: N=8, W=8 (directed + random)
  logic [63:0]  a_in_data;
  logic [2:0]   a_in_sel;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]   a_out_data;
  logic [2:0]   a_out_sel;
  logic         a_scan;
  // Instance B: N=2, W=1 (random)
  logic [1:0]   b_in_data;
  logic [0:0]   b_in_sel;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0]   b_out_data;
  logic [0:0]   b_out_sel;
  // Instance C: N=16, W=32 (random)
  logic [511:0] c_in_data;
  logic [3:0]   c_in_sel;
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0]  c_out_data;
  logic [3:0]   c_out_sel;

  mux_tree_pipe #(.N(8), .W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
`ifdef MUX_TREE_SCAN_EN
    , .scan_mode(a_scan)
`endif
  );

  mux_tree_pipe #(.N(2), .W(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
`ifdef MUX_TREE_SCAN_EN
    , .scan_mode(1'b0)
`endif
  );

  mux_tree_pipe #(.N(16), .W(32)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_sel(c_in_sel), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_sel(c_out_sel), .out_valid(c_out_valid),
    .out_ready(c_out_ready)
`ifdef MUX_TREE_SCAN_EN
    , .scan_mode(1'b0)
`endif
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  s;
  } slot_t;

  // Each queue holds exactly LOG2N slots; the front is what the output must show.
  slot_t       qa[$], qb[$], qc[$];
  int unsigned a_cnt;
  logic        a_acc;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_init();
    slot_t e;
    e.v = 1'b0;
    e.d = '0;
    e.s = '0;
    qa = {};
    qb = {};
    qc = {};
    repeat (3) qa.push_back(e);
    repeat (1) qb.push_back(e);
    repeat (4) qc.push_back(e);
    a_cnt = 0;
  endtask

  task automatic rand_bc();
    b_in_data   = 2'($urandom);
    b_in_sel    = 1'($urandom);
    b_in_valid  = ($urandom_range(0, 3) != 0);
    b_out_ready = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < 16; i++) c_in_data[i*32 +: 32] = $urandom;
    c_in_sel    = 4'($urandom);
    c_in_valid  = ($urandom_range(0, 3) != 0);
    c_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic rand_a_beat();
    a_in_data = {$urandom, $urandom};
    a_in_sel  = 3'($urandom);
  endtask

  // One clock: update the model from the inputs, take the edge, compare outputs.
  task automatic tick();
    slot_t        s;
    logic         adv;
    logic [3:0]   esel;
    logic [63:0]  ta;
    logic [511:0] tc;
    #1;
    adv = !qa[0].v || a_out_ready;
    check("a_in_ready", 32'(a_in_ready), 32'(adv));
    a_acc = adv && a_in_valid;
    if (adv) begin
      esel = a_scan ? 4'(a_cnt) : {1'b0, a_in_sel};
      ta   = a_in_data >> (esel * 8);
      s.v  = a_in_valid;
      s.s  = esel;
      s.d  = {24'd0, ta[7:0]};
      if (a_in_valid && a_scan) a_cnt = (a_cnt + 1) % 8;
      void'(qa.pop_front());
      qa.push_back(s);
    end
    adv = !qb[0].v || b_out_ready;
    check("b_in_ready", 32'(b_in_ready), 32'(adv));
    if (adv) begin
      s.v = b_in_valid;
      s.s = {3'd0, b_in_sel};
      s.d = 32'(b_in_data[b_in_sel]);
      void'(qb.pop_front());
      qb.push_back(s);
    end
    adv = !qc[0].v || c_out_ready;
    check("c_in_ready", 32'(c_in_ready), 32'(adv));
    if (adv) begin
      tc  = c_in_data >> (c_in_sel * 32);
      s.v = c_in_valid;
      s.s = c_in_sel;
      s.d = tc[31:0];
      void'(qc.pop_front());
      qc.push_back(s);
    end
    @(posedge clk);
    #1;
    check("a_out_valid", 32'(a_out_valid), 32'(qa[0].v));
    if (qa[0].v) begin
      check("a_out_data", 32'(a_out_data), qa[0].d);
      check("a_out_sel", 32'(a_out_sel), 32'(qa[0].s));
    end
    check("b_out_valid", 32'(b_out_valid), 32'(qb[0].v));
    if (qb[0].v) begin
      check("b_out_data", 32'(b_out_data), qb[0].d);
      check("b_out_sel", 32'(b_out_sel), 32'(qb[0].s));
    end
    check("c_out_valid", 32'(c_out_valid), 32'(qc[0].v));
    if (qc[0].v) begin
      check("c_out_data", c_out_data, qc[0].d);
      check("c_out_sel", 32'(c_out_sel), 32'(qc[0].s));
    end
    rand_bc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_a_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_data", 32'(a_out_data), 32'd0);
    check("rst_a_sel", 32'(a_out_sel), 32'd0);
    check("rst_b_valid", 32'(b_out_valid), 32'd0);
    check("rst_c_valid", 32'(c_out_valid), 32'd0);
    check("rst_c_data", c_out_data, 32'd0);
    model_init();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int         sent;
    logic [4:0] pat;
    a_in_data   = '0;
    a_in_sel    = '0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_scan      = 1'b0;
    a_acc       = 1'b0;
    rand_bc();
    model_init();
    #2;
    do_reset();

    // Select sweep: input i = A0+i, selects 0..7 back to back.
    for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'(8'hA0 + i);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_sel = 3'(i);
      tick();
    end
    a_in_valid = 1'b0;
    repeat (4) tick();

    // Backpressure: 5 beats, out_ready low for 4 cycles once output is valid.
    sent = 0;
    rand_a_beat();
    for (int i = 0; i < 16; i++) begin
      a_in_valid  = (sent < 5);
      a_out_ready = !(i >= 3 && i < 7);
      tick();
      if (a_acc) begin
        sent++;
        rand_a_beat();
      end
    end
    check("bp_accepted", 32'(sent), 32'd5);

    // Bubbles: valid pattern 1,0,1,1,0.
    a_out_ready = 1'b1;
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      rand_a_beat();
      a_in_valid = pat[i];
      tick();
    end
    a_in_valid = 1'b0;
    repeat (4) tick();

    // Reset with two beats in flight; nothing stale may emerge afterwards.
    a_in_valid = 1'b1;
    repeat (2) begin
      rand_a_beat();
      tick();
    end
    a_in_valid = 1'b0;
    do_reset();
    repeat (5) tick();

    // Random traffic on all instances.
    repeat (300) begin
      rand_a_beat();
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    repeat (4) tick();

`ifdef MUX_TREE_SCAN_EN
    // Auto-scan: in_sel held at 5, ten accepted beats with a stall in between.
    a_scan     = 1'b1;
    a_in_sel   = 3'd5;
    a_in_valid = 1'b1;
    sent = 0;
    for (int i = 0; i < 40 && sent < 10; i++) begin
      rand_a_beat();
      a_in_sel    = 3'd5;
      a_out_ready = !(i == 6 || i == 7);
      tick();
      if (a_acc) sent++;
    end
    check("scan_accepted", 32'(sent), 32'd10);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    repeat (4) tick();
    a_scan = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
